// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle MIPS core: sequences IF/ID/EX/MEM/WB and
// drives the datapath enables, mux selects and the ALUOp class from state + decode.
module multi_cycle_controller #(
  parameter int unsigned ST_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      OpCode,
  input  logic [5:0]      Funct,
  output logic [ST_W-1:0] State,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [2:0]      ALUOp,
  output logic            InstrDone,
  output logic            IllegalOp
);

  localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
  localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
  localparam logic [ST_W-1:0] S_EX  = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEM = ST_W'(3);
  localparam logic [ST_W-1:0] S_WB  = ST_W'(4);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  logic is_r, is_j, is_jal, is_jr, is_jalr, is_beq, is_lw, is_sw;
  logic is_iarith, is_andi, is_slt_imm;
  logic op_legal, fn_legal, illegal, id_done;

  // Instruction class decode from IR fields
  assign is_r       = (OpCode == OP_R);
  assign is_j       = (OpCode == OP_J);
  assign is_jal     = (OpCode == OP_JAL);
  assign is_beq     = (OpCode == OP_BEQ);
  assign is_lw      = (OpCode == OP_LW);
  assign is_sw      = (OpCode == OP_SW);
  assign is_andi    = (OpCode == OP_ANDI);
  assign is_slt_imm = (OpCode == OP_SLTI) || (OpCode == OP_SLTIU);
  assign is_iarith  = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_LUI) ||
                      is_andi || is_slt_imm;
  assign is_jr      = is_r && (Funct == FN_JR);
  assign is_jalr    = is_r && (Funct == FN_JALR);

  assign fn_legal = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA) ||
                    (Funct == FN_JR) || (Funct == FN_JALR) || (Funct[5:3] == 3'b100) ||
                    (Funct == FN_SLT) || (Funct == FN_SLTU);
  assign op_legal = is_r || is_j || is_jal || is_beq || is_iarith || is_lw || is_sw;
  assign illegal  = !op_legal || (is_r && !fn_legal);
  assign id_done  = illegal || is_j || is_jal || is_jr || is_jalr;

  assign State = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = id_done ? S_IF : S_EX;
      S_EX: begin
        if (is_lw || is_sw)          state_d = S_MEM;
        else if (is_r || is_iarith)  state_d = S_WB;
        else                         state_d = S_IF;
      end
      S_MEM: state_d = is_lw ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Output decode; reset and unreachable encodings leave everything at zero
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    InstrDone   = 1'b0;
    IllegalOp   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          if (illegal) begin
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
          end else if (is_j || is_jal) begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            InstrDone = 1'b1;
            if (is_jal) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end else if (is_jr || is_jalr) begin
            PCWrite   = 1'b1;
            PCSource  = 2'b11;
            InstrDone = 1'b1;
            if (is_jalr) begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemtoReg = 2'b10;
            end
          end
        end
        S_EX: begin
          ALUSrcA = 1'b1;
          if (is_beq) begin
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            InstrDone   = 1'b1;
          end else if (is_r) begin
            ALUOp = ALU_R;
          end else if (is_lw || is_sw || is_iarith) begin
            ALUSrcB = 2'b10;
            if (is_andi)         ALUOp = ALU_AND;
            else if (is_slt_imm) ALUOp = ALU_SLT;
          end
        end
        S_MEM: begin
          IorD = 1'b1;
          if (is_lw) begin
            MemRead = 1'b1;
          end else if (is_sw) begin
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
          end
        end
        S_WB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          if (is_lw)     MemtoReg = 2'b01;
          else if (is_r) RegDst   = 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: directed instruction sequences push
// hand-derived per-cycle control vectors; a negedge monitor pops and compares.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic [2:0] State;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic       ALUSrcA, InstrDone, IllegalOp;
  logic [2:0] ALUOp;

  typedef struct {
    logic [23:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [23:0] v_if, v_id, v_zero_if, v_arith_wb;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .State(State),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // Packs {State,PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,
  //        RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSource,ALUOp,InstrDone,IllegalOp}
  function automatic logic [23:0] mk(input int st, input int pcw, input int pcwc,
                                     input int iord, input int mr, input int mw,
                                     input int irw, input int rw, input int rd,
                                     input int m2r, input int asa, input int asb,
                                     input int pcs, input int aop, input int done,
                                     input int ill);
    return {3'(st), 1'(pcw), 1'(pcwc), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rw),
            2'(rd), 2'(m2r), 1'(asa), 2'(asb), 2'(pcs), 3'(aop), 1'(done), 1'(ill)};
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic [23:0] v, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = r;
    OpCode = op;
    Funct  = fn;
    e.v    = v;
    e.name = nm;
    q.push_back(e);
  endtask

  // IR not yet loaded in IF: drive junk fields to show they are ignored
  task automatic fetch(input string nm);
    step(1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), v_if, nm);
  endtask

  task automatic arith_i(input logic [5:0] op, input int aop, input string nm);
    fetch({nm, ".IF"});
    step(1'b0, op, 6'h00, v_id, {nm, ".ID"});
    step(1'b0, op, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,1,2,0,aop,0,0), {nm, ".EX"});
    step(1'b0, op, 6'h00, v_arith_wb, {nm, ".WB"});
  endtask

  // Monitor: one comparison per presented cycle while expectations are queued
  initial begin
    logic [23:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp};
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %06h expected %06h", e.name, act, e.v);
        end
      end
    end
  end

  initial begin
    v_if       = mk(0,1,0,0,1,0,1,0,0,0,0,1,0,0,0,0);
    v_id       = mk(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0);
    v_zero_if  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v_arith_wb = mk(4,0,0,0,0,0,0,1,0,0,0,0,0,0,1,0);
    reset  = 1'b1;
    OpCode = 6'h00;
    Funct  = 6'h00;

    step(1'b1, 6'h23, 6'h00, v_zero_if, "reset0");
    step(1'b1, 6'h23, 6'h00, v_zero_if, "reset1");

    // lw, full path
    fetch("lw.IF");
    step(1'b0, 6'h23, 6'h00, v_id, "lw.ID");
    step(1'b0, 6'h23, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), "lw.EX");
    step(1'b0, 6'h23, 6'h00, mk(3,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0), "lw.MEM");
    step(1'b0, 6'h23, 6'h00, mk(4,0,0,0,0,0,0,1,0,1,0,0,0,0,1,0), "lw.WB");

    // add then sw
    fetch("add.IF");
    step(1'b0, 6'h00, 6'h20, v_id, "add.ID");
    step(1'b0, 6'h00, 6'h20, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,2,0,0), "add.EX");
    step(1'b0, 6'h00, 6'h20, mk(4,0,0,0,0,0,0,1,1,0,0,0,0,0,1,0), "add.WB");
    fetch("sw.IF");
    step(1'b0, 6'h2b, 6'h00, v_id, "sw.ID");
    step(1'b0, 6'h2b, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), "sw.EX");
    step(1'b0, 6'h2b, 6'h00, mk(3,0,0,1,0,1,0,0,0,0,0,0,0,0,1,0), "sw.MEM");

    // beq
    fetch("beq.IF");
    step(1'b0, 6'h04, 6'h00, v_id, "beq.ID");
    step(1'b0, 6'h04, 6'h00, mk(2,0,1,0,0,0,0,0,0,0,1,0,1,1,1,0), "beq.EX");

    // jumps resolve in ID
    fetch("j.IF");
    step(1'b0, 6'h02, 6'h00, mk(1,1,0,0,0,0,0,0,0,0,0,3,2,0,1,0), "j.ID");
    fetch("jal.IF");
    step(1'b0, 6'h03, 6'h00, mk(1,1,0,0,0,0,0,1,2,2,0,3,2,0,1,0), "jal.ID");
    fetch("jr.IF");
    step(1'b0, 6'h00, 6'h08, mk(1,1,0,0,0,0,0,0,0,0,0,3,3,0,1,0), "jr.ID");
    fetch("jalr.IF");
    step(1'b0, 6'h00, 6'h09, mk(1,1,0,0,0,0,0,1,1,2,0,3,3,0,1,0), "jalr.ID");

    // illegal opcode and illegal R-type funct
    fetch("ill_op.IF");
    step(1'b0, 6'h3f, 6'h00, mk(1,0,0,0,0,0,0,0,0,0,0,3,0,0,1,1), "ill_op.ID");
    fetch("ill_fn.IF");
    step(1'b0, 6'h00, 6'h01, mk(1,0,0,0,0,0,0,0,0,0,0,3,0,0,1,1), "ill_fn.ID");

    // I-arith ALUOp classes
    arith_i(6'h0c, 3, "andi");
    arith_i(6'h0a, 4, "slti");
    arith_i(6'h0f, 0, "lui");

    // sll (funct 00) is a legal R-type going through EX/WB
    fetch("sll.IF");
    step(1'b0, 6'h00, 6'h00, v_id, "sll.ID");
    step(1'b0, 6'h00, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,2,0,0), "sll.EX");
    step(1'b0, 6'h00, 6'h00, mk(4,0,0,0,0,0,0,1,1,0,0,0,0,0,1,0), "sll.WB");

    // reset held two cycles during lw WB: no RegWrite, then IF
    fetch("rst_lw.IF");
    step(1'b0, 6'h23, 6'h00, v_id, "rst_lw.ID");
    step(1'b0, 6'h23, 6'h00, mk(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), "rst_lw.EX");
    step(1'b0, 6'h23, 6'h00, mk(3,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0), "rst_lw.MEM");
    step(1'b1, 6'h23, 6'h00, mk(4,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst_lw.WB_rst");
    step(1'b1, 6'h23, 6'h00, v_zero_if, "rst_lw.hold");
    fetch("post_rst.IF");
    step(1'b0, 6'h02, 6'h00, mk(1,1,0,0,0,0,0,0,0,0,0,3,2,0,1,0), "post_rst.j.ID");
    fetch("post_rst2.IF");

    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
